// File: rtl/sbox_scheduler.sv
// Shares one AES S-box between SubBytes (128-bit state) and SubWord (32-bit key word) jobs.
// Define SBOX_OUT_REG_EN to register the S-box output (adds one drain cycle per job).
module sbox_scheduler (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_in,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_in,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW, DONE} state_t;
  localparam logic GRANT_ST = 1'b0;
  localparam logic GRANT_KW = 1'b1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  state_t         state, state_nxt;
  logic   [127:0] work, work_nxt;
  logic   [3:0]   idx, last_idx;
  logic           last_grant, grant_kw;
  logic           running, lookup_en, last_lookup, leave_run;
  logic   [7:0]   sbox_res, wr_data;
  logic   [3:0]   wr_idx;
  logic           wr_en;

  assign running     = (state == RUN_ST) || (state == RUN_KW);
  assign last_idx    = (state == RUN_KW) ? 4'd3 : 4'd15;
  assign sbox_res    = sbox(work[{idx, 3'b000} +: 8]);
  assign last_lookup = lookup_en && (idx == last_idx);

`ifdef SBOX_OUT_REG_EN
  logic [7:0] sbox_q_p0;
  logic [3:0] wr_idx_p0;
  logic       vld_p0;
  logic       drain;

  assign lookup_en = running && !drain;
  assign leave_run = running && drain;
  assign wr_data   = sbox_q_p0;
  assign wr_idx    = wr_idx_p0;
  assign wr_en     = running && vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      drain  <= 1'b0;
    end else begin
      vld_p0 <= lookup_en;
      if (last_lookup)    drain <= 1'b1;
      else if (leave_run) drain <= 1'b0;
    end
  end

  // S-box output stage
  always_ff @(posedge clk) begin
    sbox_q_p0 <= sbox_res;
    wr_idx_p0 <= idx;
  end
`else
  assign lookup_en = running;
  assign leave_run = last_lookup;
  assign wr_data   = sbox_res;
  assign wr_idx    = idx;
  assign wr_en     = running;
`endif

  always_comb begin
    work_nxt = work;
    if (wr_en) work_nxt[{wr_idx, 3'b000} +: 8] = wr_data;
  end

  // Round-robin: on contention serve whoever was not served last.
  always_comb begin
    grant_kw = kw_req_valid;
    if (st_req_valid && kw_req_valid) grant_kw = (last_grant == GRANT_ST);
  end

  assign st_req_ready = (state == IDLE) && st_req_valid && !grant_kw;
  assign kw_req_ready = (state == IDLE) && kw_req_valid && grant_kw;
  assign st_done      = (state == DONE) && (last_grant == GRANT_ST);
  assign kw_done      = (state == DONE) && (last_grant == GRANT_KW);
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (st_req_ready)      state_nxt = RUN_ST;
        else if (kw_req_ready) state_nxt = RUN_KW;
      end
      RUN_ST, RUN_KW: if (leave_run) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      last_grant <= GRANT_ST;
      st_out     <= '0;
      kw_out     <= '0;
    end else begin
      state <= state_nxt;
      if (st_req_ready || kw_req_ready) begin
        idx        <= 4'd0;
        last_grant <= grant_kw;
      end else if (lookup_en && !last_lookup) begin
        idx <= idx + 4'd1;
      end
      if (leave_run && last_grant == GRANT_ST) st_out <= work_nxt;
      if (leave_run && last_grant == GRANT_KW) kw_out <= work_nxt[31:0];
    end
  end

  // Job data register
  always_ff @(posedge clk) begin
    if (st_req_ready)      work <= st_in;
    else if (kw_req_ready) work <= {96'd0, kw_in};
    else if (running)      work <= work_nxt;
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed self-checking bench for sbox_scheduler (honours SBOX_OUT_REG_EN for latency).
module tb_sbox_scheduler;

`ifdef SBOX_OUT_REG_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif

  localparam logic [127:0] ST_A     = 128'h0000000000faeacab6977569594b3325;
  localparam logic [127:0] ST_A_EXP = 128'h63636363632d87744e889df9cbb3c33f;
  localparam logic [127:0] ST_B     = {16{8'h53}};
  localparam logic [127:0] ST_B_EXP = {16{8'hed}};
  localparam logic [31:0]  KW_A     = 32'h01530025;
  localparam logic [31:0]  KW_A_EXP = 32'h7ced633f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_req_valid = 1'b0;
  logic         st_req_ready;
  logic [127:0] st_in = '0;
  logic         st_done;
  logic [127:0] st_out;
  logic         kw_req_valid = 1'b0;
  logic         kw_req_ready;
  logic [31:0]  kw_in = '0;
  logic         kw_done;
  logic [31:0]  kw_out;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int st_hs, st_hs_n, st_done_c, st_done_n;
  int kw_hs, kw_hs_n, kw_done_c, kw_done_n;
  logic [127:0] st_res;
  logic [31:0]  kw_res;

  sbox_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .st_req_valid (st_req_valid),
    .st_req_ready (st_req_ready),
    .st_in        (st_in),
    .st_done      (st_done),
    .st_out       (st_out),
    .kw_req_valid (kw_req_valid),
    .kw_req_ready (kw_req_ready),
    .kw_in        (kw_in),
    .kw_done      (kw_done),
    .kw_out       (kw_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    st_hs_n = 0; st_done_n = 0; kw_hs_n = 0; kw_done_n = 0;
    st_hs = 0; st_done_c = 0; kw_hs = 0; kw_done_c = 0;
    st_res = '0; kw_res = '0;
  end

  always @(negedge clk) begin
    if (!rst && st_req_valid && st_req_ready) begin st_hs = cyc; st_hs_n++; end
    if (!rst && kw_req_valid && kw_req_ready) begin kw_hs = cyc; kw_hs_n++; end
    if (st_done) begin st_done_c = cyc; st_res = st_out; st_done_n++; end
    if (kw_done) begin kw_done_c = cyc; kw_res = kw_out; kw_done_n++; end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_hs(input bit kw, input int n0);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if ((kw ? kw_hs_n : st_hs_n) > n0) seen = 1;
    end
    check(kw ? "kw_hs_timeout" : "st_hs_timeout", 128'(seen), 128'd1);
  endtask

  task automatic wait_done(input bit kw, input int n0);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if ((kw ? kw_done_n : st_done_n) > n0) seen = 1;
    end
    check(kw ? "kw_done_timeout" : "st_done_timeout", 128'(seen), 128'd1);
  endtask

  task automatic issue_st(input logic [127:0] d);
    int n0 = st_hs_n;
    st_in = d; st_req_valid = 1'b1;
    wait_hs(1'b0, n0);
    st_req_valid = 1'b0;
  endtask

  task automatic issue_kw(input logic [31:0] d);
    int n0 = kw_hs_n;
    kw_in = d; kw_req_valid = 1'b1;
    wait_hs(1'b1, n0);
    kw_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n0, k0, h0;
    do_reset();
    check("rst_st_out", st_out, '0);
    check("rst_kw_out", 128'(kw_out), '0);
    check("rst_busy", 128'(busy), '0);
    check("rst_dones", 128'({st_done, kw_done}), '0);
    check("rst_readys", 128'({st_req_ready, kw_req_ready}), '0);

    // Single SubBytes job
    n0 = st_done_n;
    issue_st(ST_A);
    check("st_busy_t1", 128'(busy), 128'd1);
    wait_done(1'b0, n0);
    check("st_done_t", 128'(st_done_c - st_hs), 128'(17 + X));
    check("st_out_a", st_res, ST_A_EXP);
    check("st_busy_after", 128'(busy), '0);
    check("kw_out_hold", 128'(kw_out), '0);

    // Single SubWord job
    n0 = kw_done_n;
    issue_kw(KW_A);
    check("kw_busy_t1", 128'(busy), 128'd1);
    wait_done(1'b1, n0);
    check("kw_done_t", 128'(kw_done_c - kw_hs), 128'(5 + X));
    check("kw_out_a", 128'(kw_res), 128'(KW_A_EXP));
    check("kw_busy_after", 128'(busy), '0);
    check("st_out_hold", st_out, ST_A_EXP);

    // Contention right after reset: KW first
    do_reset();
    n0 = st_done_n; k0 = kw_hs_n;
    fork
      issue_st(ST_B);
      issue_kw(KW_A);
    join
    wait_done(1'b0, n0);
    check("cont_kw_first", 128'(kw_hs_n - k0), 128'd1);
    check("cont_st_hs_t", 128'(st_hs - kw_hs), 128'(6 + X));
    check("cont_st_done_t", 128'(st_done_c - kw_hs), 128'(23 + 2 * X));
    check("cont_st_val", st_res, ST_B_EXP);
    check("cont_kw_val", 128'(kw_res), 128'(KW_A_EXP));

    // After a lone KW job, contention must favour ST
    n0 = kw_done_n;
    issue_kw(KW_A);
    wait_done(1'b1, n0);
    fork
      issue_st(ST_A);
      issue_kw(KW_A);
    join
    check("rr_st_first", 128'(st_hs < kw_hs), 128'd1);
    check("rr_kw_gap", 128'(kw_hs - st_hs), 128'(18 + X));
    n0 = kw_done_n;
    wait_done(1'b1, n0);

    // Reset at T8 of an ST job
    n0 = st_done_n;
    issue_st(ST_B);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_busy", 128'(busy), '0);
    check("mid_st_out", st_out, '0);
    repeat (25) @(posedge clk);
    #1 check("mid_no_done", 128'(st_done_n - n0), '0);
    issue_st(ST_A);
    wait_done(1'b0, n0);
    check("mid_reissue", st_res, ST_A_EXP);

    // Held valid with data changed after the handshake
    n0 = st_hs_n; k0 = st_done_n;
    st_in = ST_A; st_req_valid = 1'b1;
    wait_hs(1'b0, n0);
    h0 = st_hs;
    st_in = ST_B;
    wait_hs(1'b0, n0 + 1);
    st_req_valid = 1'b0;
    check("held_first_val", st_res, ST_A_EXP);
    check("held_next_hs", 128'(st_hs - h0), 128'(18 + X));
    wait_done(1'b0, k0 + 1);
    check("held_second_val", st_res, ST_B_EXP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
